// File: rtl/inst_loader.sv
// Assembles big-endian bytes from the UART receiver into instruction words and
// writes them to IMEM, stopping after the HALT word or when IMEM runs out.
module inst_loader #(
    parameter int                 NB_DATA   = 8,
    parameter int                 INSBITS   = 32,
    parameter int                 ADDR_BITS = 8,
    parameter logic [INSBITS-1:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [NB_DATA-1:0]   i_rx_data,
    input  logic                 i_rx_valid,
    output logic                 o_wr_en,
    output logic [ADDR_BITS-1:0] o_wr_addr,
    output logic [INSBITS-1:0]   o_wr_data,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_overflow,
    output logic [ADDR_BITS:0]   o_inst_count
);

    localparam int NBYTES = INSBITS / NB_DATA;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t               state_q, state_d;
    logic [INSBITS-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [ADDR_BITS:0]   count_q, count_d;

    logic [INSBITS-1:0]   shift_in;
    assign shift_in = {shift_q[INSBITS-NB_DATA-1:0], i_rx_data};

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            addr_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        addr_d     = addr_q;
        count_d    = count_q;

        if (i_start) begin
            // A restart always wins; any byte arriving alongside it is discarded.
            state_d    = S_RECV;
            byte_cnt_d = '0;
            addr_d     = '0;
            count_d    = '0;
        end else begin
            case (state_q)
                S_RECV: begin
                    if (i_rx_valid) begin
                        shift_d = shift_in;
                        if (byte_cnt_q == LAST_BYTE) begin
                            byte_cnt_d = '0;
                            state_d    = S_WRITE;
                        end else begin
                            byte_cnt_d = byte_cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_WRITE: begin
                    count_d = count_q + (ADDR_BITS+1)'(1);
                    if (shift_q == HALT_WORD) begin
                        state_d = S_DONE;
                    end else if (addr_q == '1) begin
                        state_d = S_ERROR;
                    end else begin
                        addr_d  = addr_q + ADDR_BITS'(1);
                        state_d = S_RECV;
                        // A byte landing during the write cycle opens the next word.
                        if (i_rx_valid) begin
                            shift_d    = shift_in;
                            byte_cnt_d = CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_wr_en      = (state_q == S_WRITE);
        o_wr_addr    = addr_q;
        o_wr_data    = shift_q;
        o_busy       = (state_q == S_RECV) || (state_q == S_WRITE);
        o_done       = (state_q == S_DONE);
        o_overflow   = (state_q == S_ERROR);
        o_inst_count = count_q;
    end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: a full-depth instance and a 4-word instance
// share one byte stream so the overflow and last-address cases can be observed.
module tb_inst_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;

    logic        wr_en_b, busy_b, done_b, ovf_b;
    logic [7:0]  addr_b;
    logic [31:0] data_b;
    logic [8:0]  count_b;

    logic        wr_en_s, busy_s, done_s, ovf_s;
    logic [1:0]  addr_s;
    logic [31:0] data_s;
    logic [2:0]  count_s;

    int n_cmp;
    int n_bad;

    inst_loader #(.ADDR_BITS(8)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_start(start),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_wr_en(wr_en_b), .o_wr_addr(addr_b), .o_wr_data(data_b),
        .o_busy(busy_b), .o_done(done_b), .o_overflow(ovf_b),
        .o_inst_count(count_b)
    );

    inst_loader #(.ADDR_BITS(2)) dut_small (
        .i_clk(clk), .i_reset(rst_n), .i_start(start),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_wr_en(wr_en_s), .o_wr_addr(addr_s), .o_wr_data(data_s),
        .o_busy(busy_s), .o_done(done_s), .o_overflow(ovf_s),
        .o_inst_count(count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        n_cmp    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tick();
        tick();

        chk_eq("rst_wr_en",  wr_en_b, 0);
        chk_eq("rst_busy",   busy_b,  0);
        chk_eq("rst_done",   done_b,  0);
        chk_eq("rst_ovf",    ovf_b,   0);
        chk_eq("rst_count",  count_b, 0);
        chk_eq("rst_addr",   addr_b,  0);
        chk_eq("rst_data",   data_b,  0);

        rst_n = 1'b1;
        tick();
        // Bytes in IDLE must be ignored.
        send_word(32'h11223344);
        chk_eq("idle_no_wr",   wr_en_b, 0);
        chk_eq("idle_no_busy", busy_b,  0);

        // Test 1: three-word program ending in HALT.
        pulse_start();
        chk_eq("t1_busy", busy_b, 1);
        send_word(32'h20080005);
        chk_eq("t1_w0_en",   wr_en_b, 1);
        chk_eq("t1_w0_addr", addr_b,  0);
        chk_eq("t1_w0_data", data_b,  32'h20080005);
        tick();
        chk_eq("t1_w0_cnt",  count_b, 1);
        chk_eq("t1_w0_off",  wr_en_b, 0);
        send_word(32'h00000000);
        chk_eq("t1_w1_addr", addr_b,  1);
        chk_eq("t1_w1_data", data_b,  32'h00000000);
        tick();
        send_word(32'hFFFFFFFF);
        chk_eq("t1_w2_en",   wr_en_b, 1);
        chk_eq("t1_w2_addr", addr_b,  2);
        chk_eq("t1_w2_data", data_b,  32'hFFFFFFFF);
        tick();
        chk_eq("t1_done",    done_b,  1);
        chk_eq("t1_count",   count_b, 3);
        chk_eq("t1_ovf",     ovf_b,   0);
        chk_eq("t1_busy_lo", busy_b,  0);

        // Test 2: four plain words fill the 4-word instance -> overflow.
        pulse_start();
        chk_eq("t2_done_clr", done_b, 0);
        for (int i = 0; i < 4; i++) begin
            w = 32'h01000000 + 32'(i);
            send_word(w);
            chk_eq($sformatf("t2_w%0d_en", i),   wr_en_s, 1);
            chk_eq($sformatf("t2_w%0d_addr", i), addr_s,  i);
            chk_eq($sformatf("t2_w%0d_data", i), data_s,  w);
            tick();
        end
        chk_eq("t2_ovf",   ovf_s,   1);
        chk_eq("t2_count", count_s, 4);
        chk_eq("t2_done",  done_s,  0);
        chk_eq("t2_busy",  busy_s,  0);
        send_word(32'h55667788);
        chk_eq("t2_no_wr_a", wr_en_s, 0);
        tick();
        chk_eq("t2_no_wr_b", wr_en_s, 0);
        chk_eq("t2_ovf_held", ovf_s, 1);

        // Test 3: HALT at the last address of the 4-word instance -> done.
        pulse_start();
        chk_eq("t3_ovf_clr", ovf_s, 0);
        for (int i = 0; i < 3; i++) begin
            send_word(32'h0A000000 + 32'(i));
            tick();
        end
        send_word(32'hFFFFFFFF);
        chk_eq("t3_halt_en",   wr_en_s, 1);
        chk_eq("t3_halt_addr", addr_s,  3);
        chk_eq("t3_halt_data", data_s,  32'hFFFFFFFF);
        tick();
        chk_eq("t3_done",  done_s,  1);
        chk_eq("t3_ovf",   ovf_s,   0);
        chk_eq("t3_count", count_s, 4);

        // Test 4: start and a byte in the same cycle -> byte dropped.
        start    = 1'b1;
        rx_data  = 8'hAA;
        rx_valid = 1'b1;
        tick();
        start    = 1'b0;
        rx_valid = 1'b0;
        send_word(32'h12345678);
        chk_eq("t4_en",   wr_en_b, 1);
        chk_eq("t4_addr", addr_b,  0);
        chk_eq("t4_data", data_b,  32'h12345678);

        // Test 5: byte during the WRITE cycle starts the next word.
        send_byte(8'h8C);
        send_byte(8'h22);
        send_byte(8'h00);
        send_byte(8'h04);
        chk_eq("t5_en",   wr_en_b, 1);
        chk_eq("t5_addr", addr_b,  1);
        chk_eq("t5_data", data_b,  32'h8C220004);
        tick();
        chk_eq("t5_count", count_b, 2);

        // Test 6: reset after two bytes abandons the partial word.
        send_byte(8'h9A);
        send_byte(8'hBC);
        rst_n = 1'b0;
        tick();
        chk_eq("t6_en",    wr_en_b, 0);
        chk_eq("t6_busy",  busy_b,  0);
        chk_eq("t6_count", count_b, 0);
        chk_eq("t6_addr",  addr_b,  0);
        chk_eq("t6_data",  data_b,  0);
        rst_n = 1'b1;
        send_byte(8'hDE);
        send_byte(8'hF0);
        chk_eq("t6_idle_no_wr", wr_en_b, 0);
        pulse_start();
        send_word(32'hDEADBEEF);
        chk_eq("t6_re_en",   wr_en_b, 1);
        chk_eq("t6_re_addr", addr_b,  0);
        chk_eq("t6_re_data", data_b,  32'hDEADBEEF);
        tick();
        chk_eq("t6_re_cnt",  count_b, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
